// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants and sequencer state encoding for the Sobel stream wrapper
package sobel_pkg;
    localparam int PIXELS_PER_BEAT = 16;
    localparam int IMAGE_DIM       = 512;
    localparam int BPR             = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int LATENCY         = 20;
    localparam int SKIP_ROWS       = 1;
    localparam int FLUSH_ROWS      = 1;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/sobel_valid_pipe.sv
// sobel_valid_pipe: enable-gated shift register tracking which core stages hold wanted beats
module sobel_valid_pipe #(
    parameter int DEPTH = 20
) (
    input  logic clk,
    input  logic aresetn,
    input  logic en,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] q;
    // shift only when the core advances so the flags stay aligned with core data
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) q <= '0;
        else if (en) q <= {q[DEPTH-2:0], din};
    end
    assign dout = q[DEPTH-1];
endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: frames AXI-Stream beats through the Sobel core, flushes it and re-frames its output
module sobel_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int LATENCY         = 20,
    parameter int SKIP_ROWS       = 1,
    parameter int FLUSH_ROWS      = 1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic [DATA_WIDTH-1:0] core_inp_frame,
    input  logic [DATA_WIDTH-1:0] core_out_frame,
    output logic                  core_stall,
    output logic                  core_rstn,
    output logic                  busy,
    output logic                  frame_err
);
    import sobel_pkg::*;
    localparam int BPR = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CW  = $clog2(BPR);
    localparam int RW  = $clog2(IMAGE_DIM + FLUSH_ROWS);
    localparam int OW  = $clog2(IMAGE_DIM);
    localparam int LW  = $clog2(LATENCY + 1);
    state_t          state, state_nx;
    logic [CW-1:0]   in_col, out_col;
    logic [RW-1:0]   in_row;
    logic [OW-1:0]   out_row;
    logic [LW-1:0]   drain_cnt;
    logic            advance, taken, vp_in, vp_out, hs, in_wrap, out_wrap, flushing;
    assign flushing       = state == FLUSH || state == DRAIN;
    assign s_tready       = state == RUN && (!m_tvalid || m_tready);
    assign advance        = state == RUN ? s_tvalid && s_tready : flushing && (!m_tvalid || m_tready);
    assign in_wrap        = in_col == CW'(BPR - 1);
    assign out_wrap       = out_col == CW'(BPR - 1);
    assign vp_in          = (state == RUN || state == FLUSH) && in_row >= RW'(SKIP_ROWS);
    assign m_tvalid       = vp_out && !taken;
    assign hs             = m_tvalid && m_tready;
    assign m_tdata        = core_out_frame;
    assign m_tlast        = m_tvalid && out_wrap;
    assign m_tuser        = m_tvalid && out_col == '0 && out_row == '0;
    assign core_inp_frame = state == RUN ? s_tdata : '0;
    assign core_stall     = !advance;
    assign core_rstn      = state != IDLE;
    assign busy           = state != IDLE;
    sobel_valid_pipe #(.DEPTH(LATENCY)) u_vpipe (
        .clk(clk), .aresetn(aresetn), .en(advance), .din(vp_in), .dout(vp_out)
    );
    // next state: frame phases are purely count-based, framing errors never alter them
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (s_tvalid && s_tuser) state_nx = RUN;
            RUN:     if (advance && in_wrap && in_row == RW'(IMAGE_DIM - 1)) state_nx = FLUSH;
            FLUSH:   if (advance && in_wrap && in_row == RW'(IMAGE_DIM + FLUSH_ROWS - 1)) state_nx = DRAIN;
            default: if (advance && drain_cnt == LW'(LATENCY - 1)) state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else state <= state_nx;
    end
    // input-side position and drain progress, cleared between frames
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn || state == IDLE) begin
            in_col    <= '0;
            in_row    <= '0;
            drain_cnt <= '0;
        end else if (advance) begin
            in_col    <= in_wrap ? '0 : in_col + 1'b1;
            in_row    <= in_row + RW'(in_wrap);
            drain_cnt <= drain_cnt + LW'(state == DRAIN);
        end
    end
    // output-side position and the "already handed over while frozen" flag
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn || state == IDLE) begin
            out_col <= '0;
            out_row <= '0;
            taken   <= 1'b0;
        end else begin
            taken <= advance ? 1'b0 : taken || hs;
            if (hs) begin
                out_col <= out_wrap ? '0 : out_col + 1'b1;
                out_row <= out_row + OW'(out_wrap);
            end
        end
    end
    // sticky framing error on accepted input beats
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) frame_err <= 1'b0;
        else if (state == RUN && advance &&
                 ((s_tuser && (in_col != '0 || in_row != '0)) || s_tlast != in_wrap))
            frame_err <= 1'b1;
    end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb_sobel_stream_ctrl: randomized frames against a beat-index model of the framed output
module tb_sobel_stream_ctrl;
    localparam int PPB = 16;
    localparam int D   = 64;
    localparam int L   = 5;
    localparam int DW  = 8 * PPB;
    localparam int BPR = D / PPB;
    localparam int NB  = D * BPR;
    logic clk = 0, aresetn = 0;
    logic [DW-1:0] s_tdata = '0, m_tdata, core_inp_frame, core_out_frame;
    logic s_tvalid = 0, s_tready, s_tuser = 0, s_tlast = 0;
    logic m_tvalid, m_tready = 0, m_tuser, m_tlast;
    logic core_stall, core_rstn, busy, frame_err;
    int checks = 0, errors = 0;
    int rdy_pct = 100;
    bit hold_lo = 0;
    always #5 clk = ~clk;
    sobel_stream_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(D), .DATA_WIDTH(DW), .LATENCY(L),
                        .SKIP_ROWS(1), .FLUSH_ROWS(1)) dut (
        .clk(clk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast), .core_inp_frame(core_inp_frame),
        .core_out_frame(core_out_frame), .core_stall(core_stall), .core_rstn(core_rstn),
        .busy(busy), .frame_err(frame_err)
    );
    // stand-in core: inverts pixels and delays them by L advances
    logic [DW-1:0] cpipe [L];
    always @(posedge clk) begin
        if (!core_rstn) for (int i = 0; i < L; i++) cpipe[i] <= '0;
        else if (!core_stall) begin
            cpipe[0] <= ~core_inp_frame;
            for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign core_out_frame = cpipe[L-1];
    always @(posedge clk) begin
        #1;
        m_tready = hold_lo ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    end
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask
    // model: output beat k is the core image of input beat k+BPR, or of a zero flush beat
    logic [DW-1:0] in_beats [NB];
    int in_cnt = 0, out_cnt = 0, adv_cnt = 0, frames_done = 0;
    bit first_seen = 0, prev_hold = 0, prev_busy = 0;
    logic [DW-1:0] prev_d, first_data, last_data, exp_d;
    logic prev_u, prev_l;
    int j;
    always @(negedge clk) begin
        if (!aresetn) begin
            in_cnt = 0; out_cnt = 0; adv_cnt = 0;
            first_seen = 0; prev_hold = 0; prev_busy = 0;
        end else begin
            if (!busy && prev_busy) begin
                chk("frame_beats", DW'(out_cnt), DW'(NB));
                chk("idle_core_rstn", DW'(core_rstn), '0);
                frames_done++;
                in_cnt = 0; out_cnt = 0; adv_cnt = 0; first_seen = 0;
            end
            if (prev_hold) begin
                chk("hold_valid", DW'(m_tvalid), DW'(1));
                chk("hold_data", m_tdata, prev_d);
                chk("hold_user", DW'(m_tuser), DW'(prev_u));
                chk("hold_last", DW'(m_tlast), DW'(prev_l));
            end
            if (s_tvalid && s_tready) begin
                if (in_cnt < NB) in_beats[in_cnt] = s_tdata;
                in_cnt++;
            end
            if (m_tvalid && !first_seen) begin
                first_seen = 1;
                chk("first_valid_adv", DW'(adv_cnt), DW'(L + BPR));
            end
            if (m_tvalid && m_tready) begin
                j = out_cnt + BPR;
                exp_d = j < NB ? ~in_beats[j] : '1;
                chk("out_data", m_tdata, exp_d);
                chk("out_user", DW'(m_tuser), DW'(out_cnt == 0));
                chk("out_last", DW'(m_tlast), DW'(out_cnt % BPR == BPR - 1));
                if (out_cnt == 0) first_data = m_tdata;
                if (out_cnt == NB - 1) last_data = m_tdata;
                out_cnt++;
            end
            if (busy && !core_stall) adv_cnt++;
            prev_hold = m_tvalid && !m_tready;
            prev_d = m_tdata; prev_u = m_tuser; prev_l = m_tlast;
            prev_busy = busy;
        end
    end
    task automatic chk_reset_vals();
        chk("rst_s_tready", DW'(s_tready), '0);
        chk("rst_m_tvalid", DW'(m_tvalid), '0);
        chk("rst_m_tuser", DW'(m_tuser), '0);
        chk("rst_m_tlast", DW'(m_tlast), '0);
        chk("rst_core_stall", DW'(core_stall), DW'(1));
        chk("rst_core_rstn", DW'(core_rstn), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_frame_err", DW'(frame_err), '0);
    endtask
    task automatic pulse_reset();
        aresetn = 0;
        s_tvalid = 0; s_tuser = 0; s_tlast = 0;
        #1;
        chk_reset_vals();
        repeat (3) @(posedge clk);
        #1 aresetn = 1;
    endtask
    task automatic run_frame(input int vpct, input bit seq, input int bad_beat, input int abort_beat);
        for (int b = 0; b < NB; b++) begin
            int t = 0;
            bit acc = 0;
            s_tdata = seq ? DW'(b) : {$urandom(), $urandom(), $urandom(), $urandom()};
            s_tuser = (b == 0);
            s_tlast = ((b % BPR) == BPR - 1) ^ (b == bad_beat);
            if (b == abort_beat) begin
                pulse_reset();
                return;
            end
            while (!acc) begin
                s_tvalid = ($urandom_range(0, 99) < vpct);
                @(negedge clk);
                acc = s_tvalid && s_tready;
                @(posedge clk);
                #1;
                if (++t > 4000) begin
                    chk("input_timeout", DW'(b), DW'(-1));
                    s_tvalid = 0;
                    return;
                end
            end
        end
        s_tvalid = 0; s_tuser = 0; s_tlast = 0;
    endtask
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", DW'(busy), '0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #3_000_000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end
    initial begin
        int f0;
        logic [DW-1:0] d0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        aresetn = 1;
        @(posedge clk);
        #1;
        // full-rate deterministic frame: data = beat index
        rdy_pct = 100;
        run_frame(100, 1, -1, -1);
        wait_idle();
        chk("full_first_data", first_data, ~DW'(4));
        chk("full_last_data", last_data, {DW{1'b1}});
        chk("full_frame_err", DW'(frame_err), '0);
        // random valid/ready
        rdy_pct = 30;
        run_frame(50, 0, -1, -1);
        wait_idle();
        // long output stall mid-frame
        rdy_pct = 100;
        fork
            run_frame(100, 0, -1, -1);
            begin
                int t = 0;
                while (out_cnt < 50 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                hold_lo = 1;
                repeat (2) @(negedge clk);
                d0 = m_tdata;
                repeat (98) begin
                    @(negedge clk);
                    chk("stall_s_tready", DW'(s_tready), '0);
                    chk("stall_core_stall", DW'(core_stall), DW'(1));
                    chk("stall_m_tvalid", DW'(m_tvalid), DW'(1));
                    chk("stall_m_tdata", m_tdata, d0);
                end
                hold_lo = 0;
            end
        join
        wait_idle();
        chk("stall_frame_err", DW'(frame_err), '0);
        // bad tlast on beat 2: sticky error, framing unchanged
        rdy_pct = 70;
        run_frame(80, 0, 2, -1);
        wait_idle();
        chk("bad_last_frame_err", DW'(frame_err), DW'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("bad_last_sticky", DW'(frame_err), DW'(1));
        pulse_reset();
        // abort during row 10, then a clean frame
        rdy_pct = 100;
        run_frame(100, 0, -1, 10 * BPR + 1);
        @(posedge clk);
        #1;
        rdy_pct = 60;
        run_frame(70, 0, -1, -1);
        wait_idle();
        chk("post_abort_frame_err", DW'(frame_err), '0);
        // back-to-back frames
        f0 = frames_done;
        rdy_pct = 100;
        run_frame(100, 0, -1, -1);
        run_frame(100, 0, -1, -1);
        wait_idle();
        chk("b2b_frames", DW'(frames_done - f0), DW'(2));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
